emergency_sequencer: RTL
========================

EMERGENCY_SEQUENCER -- requirements
Module: emergency_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DEBOUNCE, default 3, SHALL be the number of consecutive high samples needed to qualify a request; legal range 1..15.
REQ-003 Parameter COOLDOWN, default 8, SHALL be the number of lockout cycles after a request clears; legal range 1..63.
REQ-004 Port: clock  in  1  rising-edge system clock.
REQ-005 Port: reset_n  in  1  asynchronous active-low reset.
REQ-006 Port: enable  in  1  high allows request detection.
REQ-007 Port: sense_north  in  1  raw emergency-vehicle sensor, north approach, active high.
REQ-008 Port: sense_south  in  1  raw emergency-vehicle sensor, south approach, active high.
REQ-009 Port: emergency  out  1  registered single-cycle pulse driving the North-South light's emergency input.
REQ-010 Port: busy  out  1  high whenever the FSM is not in IDLE.
REQ-011 Port: last_src  out  2  source of the last qualified request: 01 north, 10 south, 11 both.
REQ-012 Port: event_count  out  8  number of qualified requests, saturating.

Function
REQ-013 The block SHALL define active = sense_north OR sense_south, sampled on each rising edge of clock.
REQ-014 The FSM SHALL have exactly four states: IDLE, FIRE, HOLD, COOLDOWN.
REQ-015 IDLE: a debounce counter SHALL increment on each edge with active=1 and enable=1, and clear to 0 on any edge with active=0 or enable=0.
REQ-016 IDLE->FIRE SHALL occur on the edge where the DEBOUNCE-th consecutive qualifying sample is taken; the debounce counter SHALL clear on that edge.
REQ-017 On the IDLE->FIRE edge, last_src SHALL load {sense_south, sense_north}, and event_count SHALL increment by 1 unless it is already 255.
REQ-018 emergency SHALL be 1 for exactly the one cycle spent in FIRE, and 0 in all other states.
REQ-019 FIRE->HOLD SHALL occur unconditionally on the next edge.
REQ-020 HOLD SHALL stay in HOLD while active=1 and SHALL go to COOLDOWN on the first edge sampling active=0; a sustained sensor SHALL never produce a second pulse.
REQ-021 COOLDOWN SHALL last exactly COOLDOWN cycles, with sensors ignored, then go to IDLE with the debounce counter at 0.
REQ-022 In HOLD or COOLDOWN, enable=0 sampled on an edge SHALL force IDLE on that edge.
REQ-023 In FIRE, enable=0 SHALL NOT shorten the pulse; the FSM proceeds to HOLD and REQ-022 then applies.
REQ-024 With DEBOUNCE=1, a single high sample in IDLE SHALL qualify.
REQ-025 The debounce counter SHALL be 4 bits and the cooldown counter 6 bits, with no wrap in legal parameter ranges.
REQ-026 busy SHALL be registered, equal to (next state != IDLE), and change on the same edge as the state.
REQ-027 last_src and event_count SHALL hold their values across enable=0.

Reset
REQ-028 reset_n=0 SHALL immediately force state IDLE, both counters 0, emergency 0, busy 0, last_src 00 and event_count 0, independent of clock.
REQ-029 Reset asserted mid-pulse or mid-cooldown SHALL abort the sequence with no further pulse after release.
REQ-030 After reset_n rises, detection SHALL begin on the first rising clock edge; sensors held high through reset count from that edge.

Verification
REQ-031 enable=1; sense_north high for 3 edges then held -> emergency=1 for one cycle after edge 3; last_src=01; event_count=1; busy stays 1 while held.
REQ-032 sense_south pulses high 2 cycles, low 1 cycle, then high 2 cycles -> no emergency pulse; event_count=0.
REQ-033 Both sensors high together for 3 edges, then both low -> one pulse; last_src=11; busy falls exactly 8 cycles after the first low sample (HOLD exit plus COOLDOWN); sensors high during cooldown -> no pulse.
REQ-034 Preload event_count to 255 by 255 qualified requests, then apply one more -> the pulse is still issued and event_count stays 255.
REQ-035 enable=0 during COOLDOWN -> busy=0 on that edge; reset_n pulsed low during FIRE -> emergency drops immediately with all outputs at reset values.

Source files
------------

// File: rtl/emergency_sequencer_if.sv
// rtl/emergency_sequencer_if.sv - request inputs and status outputs of the emergency sequencer
interface emergency_sequencer_if;
  logic       enable;
  logic       sense_north;
  logic       sense_south;
  logic       emergency;
  logic       busy;
  logic [1:0] last_src;
  logic [7:0] event_count;

  modport master (
    output enable, sense_north, sense_south,
    input  emergency, busy, last_src, event_count
  );

  modport slave (
    input  enable, sense_north, sense_south,
    output emergency, busy, last_src, event_count
  );
endinterface

// File: rtl/emergency_sequencer.sv
// rtl/emergency_sequencer.sv - debounced emergency-vehicle request sequencer with one-shot pulse and cooldown
module emergency_sequencer #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned COOLDOWN = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  emergency_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FIRE     = 2'd1,
    ST_HOLD     = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE - 1);
  localparam logic [5:0] COOL_LAST = 6'(COOLDOWN - 1);

  state_t     state, state_nxt;
  logic [3:0] deb_cnt, deb_nxt;
  logic [5:0] cool_cnt, cool_nxt;
  logic       fire_load;
  logic       active;

  assign active = bus.sense_north | bus.sense_south;

  // Counters are only meaningful in their own state and read as 0 elsewhere.
  always_comb begin
    state_nxt = state;
    deb_nxt   = 4'd0;
    cool_nxt  = 6'd0;
    fire_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (active && bus.enable) begin
          if (deb_cnt == DEB_LAST) begin
            state_nxt = ST_FIRE;
            fire_load = 1'b1;
          end else begin
            deb_nxt = deb_cnt + 4'd1;
          end
        end
      end
      ST_FIRE: begin
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!bus.enable) begin
          state_nxt = ST_IDLE;
        end else if (!active) begin
          state_nxt = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (!bus.enable || (cool_cnt == COOL_LAST)) begin
          state_nxt = ST_IDLE;
        end else begin
          cool_nxt = cool_cnt + 6'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      deb_cnt         <= 4'd0;
      cool_cnt        <= 6'd0;
      bus.emergency   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.last_src    <= 2'b00;
      bus.event_count <= 8'd0;
    end else begin
      state         <= state_nxt;
      deb_cnt       <= deb_nxt;
      cool_cnt      <= cool_nxt;
      bus.emergency <= (state_nxt == ST_FIRE);
      bus.busy      <= (state_nxt != ST_IDLE);
      if (fire_load) begin
        bus.last_src <= {bus.sense_south, bus.sense_north};
        if (bus.event_count != 8'hFF) begin
          bus.event_count <= bus.event_count + 8'd1;
        end
      end
    end
  end

endmodule
